// File: rtl/panel_display_if.sv
// Front-panel display bus: CPU-side value/dots/update/blank in, LED segment and anode drive out.
interface panel_display_if;
  logic [11:0] value;
  logic [3:0]  dots;
  logic        update;
  logic        blank;
  logic [7:0]  sevenseg;
  logic [3:0]  sevenseg_an;
  logic        frame;

  modport master (
    output value, dots, update, blank,
    input  sevenseg, sevenseg_an, frame
  );

  modport slave (
    input  value, dots, update, blank,
    output sevenseg, sevenseg_an, frame
  );
endinterface

// File: rtl/panel_display.sv
// Four-digit multiplexed octal seven-segment driver with frame-aligned double buffering
// and an anode-off guard at the start of every digit slot.
module panel_display #(
  parameter int SCAN_DIV = 12500,
  parameter int GHOST    = 16
) (
  input  logic           clk,
  input  logic           reset,
  panel_display_if.slave bus
);
  localparam int            PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PCNT_TC   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] GHOST_END = PW'(GHOST);

  logic [PW-1:0] pcnt;
  logic [1:0]    idx;
  logic [15:0]   disp;
  logic [15:0]   shadow;
  logic [15:0]   live;
  logic          pending;
  logic          tc;
  logic          boundary;
  logic          in_ghost;
  logic          dot;
  logic [2:0]    digit;
  logic [6:0]    seg_code;

  assign live     = {bus.dots, bus.value};
  assign tc       = (pcnt == PCNT_TC);
  assign boundary = tc && (idx == 2'd3);
  assign in_ghost = (GHOST > 0) && (pcnt < GHOST_END);

  always_comb begin
    digit    = 3'd0;
    seg_code = 7'h7F;
    case (idx)
      2'd0: digit = disp[2:0];
      2'd1: digit = disp[5:3];
      2'd2: digit = disp[8:6];
      2'd3: digit = disp[11:9];
      default: digit = 3'd0;
    endcase
    dot = disp[{2'b11, idx}];
    // active-low g..a patterns for octal digits
    case (digit)
      3'd0: seg_code = 7'h40;
      3'd1: seg_code = 7'h79;
      3'd2: seg_code = 7'h24;
      3'd3: seg_code = 7'h30;
      3'd4: seg_code = 7'h19;
      3'd5: seg_code = 7'h12;
      3'd6: seg_code = 7'h02;
      3'd7: seg_code = 7'h78;
      default: seg_code = 7'h7F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt            <= '0;
      idx             <= 2'd0;
      disp            <= 16'h0000;
      shadow          <= 16'h0000;
      pending         <= 1'b0;
      bus.sevenseg    <= 8'hFF;
      bus.sevenseg_an <= 4'hF;
      bus.frame       <= 1'b0;
    end else begin
      if (tc) begin
        pcnt <= '0;
        idx  <= idx + 2'd1;
      end else begin
        pcnt <= pcnt + PW'(1);
      end

      if (bus.update) shadow <= live;

      // a capture coinciding with the boundary bypasses the shadow register
      if (boundary) begin
        if (bus.update)   disp <= live;
        else if (pending) disp <= shadow;
        pending <= 1'b0;
      end else if (bus.update) begin
        pending <= 1'b1;
      end

      bus.sevenseg    <= {~dot, seg_code};
      bus.sevenseg_an <= (bus.blank || in_ghost) ? 4'hF : ~(4'b0001 << idx);
      bus.frame       <= boundary;
    end
  end
endmodule

// File: tb/tb_panel_display.sv
// Scoreboard bench for panel_display: a time-based display model predicts every output cycle.
module tb_panel_display;
  localparam int SD = 8;
  localparam int GH = 2;
  localparam int FR = 4 * SD;

  typedef struct packed {
    logic       frame;
    logic [3:0] an;
    logic [7:0] seg;
  } out_t;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  always #5 sysclk = ~sysclk;

  panel_display_if bus();

  panel_display #(.SCAN_DIV(SD), .GHOST(GH)) dut (
    .clk  (sysclk),
    .reset(reset),
    .bus  (bus)
  );

  out_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          t        = 0;
  logic [15:0] latest   = 16'h0;
  logic [15:0] shown    = 16'h0;
  logic [11:0] cur_val  = 12'h0;
  logic [3:0]  cur_dts  = 4'h0;
  logic        cur_blk  = 1'b0;

  function automatic logic [7:0] seg_of(input logic [2:0] d, input logic dp);
    logic [7:0] s;
    s = 8'hFF;
    case (d)
      3'd0: s = 8'hC0;
      3'd1: s = 8'hF9;
      3'd2: s = 8'hA4;
      3'd3: s = 8'hB0;
      3'd4: s = 8'h99;
      3'd5: s = 8'h92;
      3'd6: s = 8'h82;
      3'd7: s = 8'hF8;
      default: s = 8'hFF;
    endcase
    if (dp) s[7] = 1'b0;
    return s;
  endfunction

  // t counts cycles since reset release; slot, phase and frame follow from plain division
  task automatic step(input logic rst, input logic upd, input logic [11:0] val,
                      input logic [3:0] dts, input logic blk);
    out_t        e;
    int          slot;
    int          ph;
    logic [15:0] w;
    @(negedge sysclk);
    reset      = rst;
    bus.update = upd;
    bus.value  = val;
    bus.dots   = dts;
    bus.blank  = blk;
    if (rst) begin
      e      = {1'b0, 4'hF, 8'hFF};
      t      = 0;
      latest = 16'h0;
      shown  = 16'h0;
    end else begin
      slot    = (t / SD) % 4;
      ph      = t % SD;
      w       = shown;
      e.seg   = seg_of(w[3*slot +: 3], w[12+slot]);
      e.an    = (blk || ph < GH) ? 4'hF : ~(4'b0001 << slot);
      e.frame = (t % FR == FR - 1);
      if (upd) latest = {dts, val};
      if (t % FR == FR - 1) shown = latest;
      t++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, cur_val, cur_dts, cur_blk);
  endtask

  task automatic spot(input string name, input int tgt, input logic [3:0] an_e,
                      input logic [7:0] seg_e);
    while (t < tgt) idle();
    idle();
    @(posedge sysclk);
    #2;
    n_checks++;
    if (bus.sevenseg_an !== an_e || bus.sevenseg !== seg_e) begin
      n_fail++;
      $display("FAIL %s: got an=%h seg=%h, expected an=%h seg=%h",
               name, bus.sevenseg_an, bus.sevenseg, an_e, seg_e);
    end
  endtask

  task automatic check_frame(input string name, input logic [3:0] an_e);
    @(posedge sysclk);
    #2;
    n_checks++;
    if (bus.frame !== 1'b1 || bus.sevenseg_an !== an_e) begin
      n_fail++;
      $display("FAIL %s: got frame=%b an=%h, expected frame=1 an=%h",
               name, bus.frame, bus.sevenseg_an, an_e);
    end
  endtask

  always @(posedge sysclk) begin
    out_t e;
    out_t a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.frame, bus.sevenseg_an, bus.sevenseg};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL out_stream @%0t: got frame=%b an=%h seg=%h, expected frame=%b an=%h seg=%h",
                 $time, a.frame, a.an, a.seg, e.frame, e.an, e.seg);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        chk;
    logic        upd;
    logic [11:0] rv;
    logic [3:0]  rd;
    bus.update = 1'b0;
    bus.value  = 12'h0;
    bus.dots   = 4'h0;
    bus.blank  = 1'b0;

    repeat (3) step(1'b1, 1'b0, 12'h0, 4'h0, 1'b0);
    spot("reset_first_digit", 2, 4'hE, 8'hC0);

    while (t < 10) idle();
    cur_val = 12'o1234;
    step(1'b0, 1'b1, cur_val, cur_dts, 1'b0);
    spot("no_tear_slot3", 26, 4'h7, 8'hC0);
    spot("o1234_d0", 34, 4'hE, 8'h99);
    spot("o1234_d1", 42, 4'hD, 8'hB0);
    spot("o1234_d2", 50, 4'hB, 8'hA4);
    spot("o1234_d3", 58, 4'h7, 8'hF9);

    while (t < 60) idle();
    step(1'b0, 1'b1, 12'o7777, 4'h0, 1'b0);
    idle();
    cur_val = 12'o0005;
    step(1'b0, 1'b1, cur_val, cur_dts, 1'b0);
    spot("last_wins_d0", 66, 4'hE, 8'h92);
    spot("last_wins_d1", 74, 4'hD, 8'hC0);
    spot("last_wins_d2", 82, 4'hB, 8'hC0);
    spot("last_wins_d3", 90, 4'h7, 8'hC0);

    while (t < 127) idle();
    cur_val = 12'o7000;
    cur_dts = 4'b1000;
    step(1'b0, 1'b1, cur_val, cur_dts, 1'b0);
    check_frame("boundary_frame", 4'h7);
    spot("boundary_d0", 130, 4'hE, 8'hC0);
    spot("boundary_d3_dot", 154, 4'h7, 8'h78);

    while (t < 170) idle();
    cur_blk = 1'b1;
    repeat (40) begin
      chk = (t == 191);
      idle();
      if (chk) check_frame("blank_frame", 4'hF);
    end
    cur_blk = 1'b0;
    spot("blank_release", 210, 4'hB, 8'hC0);

    repeat (1500) begin
      if ($urandom_range(0, 399) == 0) begin
        repeat ($urandom_range(1, 3)) step(1'b1, 1'b0, cur_val, cur_dts, cur_blk);
        continue;
      end
      if ($urandom_range(0, 49) == 0) cur_blk = ~cur_blk;
      upd = ($urandom_range(0, 7) == 0);
      rv  = 12'($urandom_range(0, 4095));
      rd  = 4'($urandom_range(0, 15));
      step(1'b0, upd, rv, rd, cur_blk);
    end

    cur_blk = 1'b0;
    idle();
    @(posedge sysclk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
